// File: rtl/ks_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ks_note_sequencer
// Purpose  : Step sequencer that plays a small pattern of string periods into
//            a Karplus-Strong voice. Each step lasts max(tempo_i, 2*PLUCK_HOLD)
//            cycles. The step's period is latched on entry, and a pluck pulse
//            of PLUCK_HOLD cycles opens every non-rest step.
// Ports    : clk_i, rst_ni       - clock, async active-low reset
//            start_i, stop_i     - (re)start at step 0 / abort playback
//            loop_i, len_i       - wrap after last step / index of last step
//            tempo_i             - cycles per step (floored at 2*PLUCK_HOLD)
//            wr_en_i/addr/data   - pattern write port (0 = rest)
//            period_o, pluck_o   - voice controls (registered)
//            mute_o, step_o      - rest/idle indicator, current step
//            busy_o, done_o      - playing flag, end-of-run pulse
// Revision : 1.0 - initial release
// ============================================================================
module ks_note_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int STEPS       = 8,
  parameter int TEMPO_WIDTH = 16,
  parameter int PLUCK_HOLD  = 4,
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   loop_i,
  input  logic [SW-1:0]          len_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic                   wr_en_i,
  input  logic [SW-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic                   pluck_o,
  output logic                   mute_o,
  output logic [SW-1:0]          step_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [TEMPO_WIDTH-1:0] c_HOLD     = TEMPO_WIDTH'(PLUCK_HOLD);
  localparam logic [TEMPO_WIDTH-1:0] c_MIN_STEP = TEMPO_WIDTH'(2 * PLUCK_HOLD);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SW-1:0]           r_step;
  logic [TEMPO_WIDTH-1:0]  r_tcnt;
  logic [DATA_WIDTH-1:0]   r_cur;
  logic [DATA_WIDTH-1:0]   r_pattern [STEPS];

  state_t                  w_state_nxt;
  logic [SW-1:0]           w_step_nxt;
  logic [TEMPO_WIDTH-1:0]  w_tcnt_nxt;
  logic [DATA_WIDTH-1:0]   w_cur_nxt;
  logic                    w_done_nxt;
  logic                    w_enter;
  logic [TEMPO_WIDTH-1:0]  w_step_len;
  logic                    w_step_end;
  logic                    w_sounding;
  logic                    w_pluck_nxt;

  // A zero or short tempo is stretched so every pluck is followed by at least
  // PLUCK_HOLD low cycles; the downstream synchroniser needs that gap.
  assign w_step_len = (tempo_i < c_MIN_STEP) ? c_MIN_STEP : tempo_i;

  // ">=" rather than "==" so a tempo shortened mid-step still ends the step
  // instead of letting tcnt run all the way round.
  assign w_step_end = (r_tcnt >= (w_step_len - TEMPO_WIDTH'(1)));

  // Next-state / next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_tcnt_nxt  = r_tcnt;
    w_cur_nxt   = r_cur;
    w_done_nxt  = 1'b0;
    w_enter     = 1'b0;

    if (stop_i) begin
      w_state_nxt = S_IDLE;
    end else if (start_i) begin
      w_state_nxt = S_PLAY;
      w_step_nxt  = '0;
      w_tcnt_nxt  = '0;
      w_enter     = 1'b1;
    end else if (r_state == S_PLAY) begin
      if (w_step_end) begin
        if (r_step != len_i) begin
          // Natural SW-bit wrap also covers len_i dropping below the step.
          w_step_nxt = r_step + SW'(1);
          w_tcnt_nxt = '0;
          w_enter    = 1'b1;
        end else if (loop_i) begin
          w_step_nxt = '0;
          w_tcnt_nxt = '0;
          w_enter    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_tcnt_nxt = r_tcnt + TEMPO_WIDTH'(1);
      end
    end

    // The period is captured only on step entry, so a write to the playing
    // step is heard the next time that step is entered.
    if (w_enter) begin
      w_cur_nxt = r_pattern[w_step_nxt];
    end

    w_sounding  = (w_state_nxt == S_PLAY) && (w_cur_nxt != '0);
    w_pluck_nxt = w_sounding && (w_tcnt_nxt < c_HOLD);
  end

  // State and registered outputs. Outputs are computed from next-state values
  // so they line up with the state they describe (pluck rises in the first
  // cycle of a step).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_tcnt   <= '0;
      r_cur    <= '0;
      period_o <= '0;
      pluck_o  <= 1'b0;
      mute_o   <= 1'b1;
      step_o   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_cur    <= w_cur_nxt;
      period_o <= w_cur_nxt;
      pluck_o  <= w_pluck_nxt;
      mute_o   <= !w_sounding;
      step_o   <= w_step_nxt;
      busy_o   <= (w_state_nxt == S_PLAY);
      done_o   <= w_done_nxt;
    end
  end

  // Pattern storage, writable in any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STEPS; i++) begin
        r_pattern[i] <= '0;
      end
    end else if (wr_en_i) begin
      r_pattern[wr_addr_i] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire
